// File: rtl/decode_stage_if.sv
// Bundle of the decode stage's fetch-side, execute-side, control-ROM and
// flush signals. The slave modport is the decode stage itself. The master
// modport is whatever drives it: fetch, execute, ROM and flush control.
interface decode_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        flush;
    logic [8:0]  rom_addr;
    logic [8:0]  rom_control;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [4:0]  out_rd;
    logic [31:0] out_imm;
    logic [8:0]  out_control;
    logic        out_illegal;

    modport slave (
        input  in_valid, in_instr, in_pc, flush, rom_control, out_ready,
        output in_ready, rom_addr, out_valid, out_pc, out_rs1, out_rs2,
               out_rd, out_imm, out_control, out_illegal
    );

    modport master (
        output in_valid, in_instr, in_pc, flush, rom_control, out_ready,
        input  in_ready, rom_addr, out_valid, out_pc, out_rs1, out_rs2,
               out_rd, out_imm, out_control, out_illegal
    );
endinterface

// File: rtl/decode_stage.sv
// RV32 decode stage. It has a single output register with a one-cycle
// decode latency and a valid/ready handshake on both sides. The control
// ROM is external: rom_addr is formed combinationally from in_instr, and
// rom_control comes back in the same cycle.
// Optional build macro DECODE_SKID_EN adds a one-entry skid buffer. With
// the skid, in_ready follows the skid occupancy register instead of the
// output handshake.
module decode_stage (
    input  logic          clk,
    input  logic          rst_n,
    decode_stage_if.slave bus
);

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [8:0]  control;
        logic        illegal;
    } dec_t;

    // Sign-extended immediate selected by opcode[6:2]; unknown formats give 0.
    function automatic logic [31:0] imm_gen(input logic [31:0] instr);
        logic [31:0] imm_v;
        case (instr[6:2])
            5'b00100, 5'b00000, 5'b11001:
                imm_v = {{20{instr[31]}}, instr[31:20]};
            5'b01000:
                imm_v = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            5'b11000:
                imm_v = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                         instr[11:8], 1'b0};
            5'b01101, 5'b00101:
                imm_v = {instr[31:12], 12'h000};
            5'b11011:
                imm_v = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                         instr[30:21], 1'b0};
            default:
                imm_v = 32'h0000_0000;
        endcase
        return imm_v;
    endfunction

    dec_t dec_s;
    dec_t out_r;
    dec_t out_next_s;
    logic out_valid_r;
    logic out_valid_next_s;
    logic out_load_s;
    logic in_ready_s;
    logic accept_s;
    logic consume_s;

    assign bus.rom_addr = {bus.in_instr[30], bus.in_instr[14:12], bus.in_instr[6:2]};

    // Decode the presented instruction; an illegal result forces control to 0.
    always_comb begin
        dec_s     = '0;
        dec_s.pc  = bus.in_pc;
        dec_s.rs1 = bus.in_instr[19:15];
        dec_s.rs2 = bus.in_instr[24:20];
        dec_s.rd  = bus.in_instr[11:7];
        dec_s.imm = imm_gen(bus.in_instr);
        if ((bus.in_instr[1:0] != 2'b11) || (bus.rom_control == 9'h000)) begin
            dec_s.illegal = 1'b1;
            dec_s.control = 9'h000;
        end else begin
            dec_s.illegal = 1'b0;
            dec_s.control = bus.rom_control;
        end
    end

    assign accept_s  = bus.in_valid && in_ready_s;
    assign consume_s = out_valid_r && bus.out_ready;

`ifdef DECODE_SKID_EN
    dec_t skid_r;
    logic skid_valid_r;
    logic skid_valid_next_s;
    logic skid_load_s;
    logic out_from_skid_s;

    // Ready tracks skid emptiness. Flush and reset also block acceptance.
    assign in_ready_s = rst_n && !skid_valid_r && !bus.flush;

    // Next-state for the output register and the skid. Flush wins over everything.
    always_comb begin
        out_valid_next_s  = out_valid_r;
        out_load_s        = 1'b0;
        out_from_skid_s   = 1'b0;
        skid_valid_next_s = skid_valid_r;
        skid_load_s       = 1'b0;
        if (bus.flush) begin
            out_valid_next_s  = 1'b0;
            skid_valid_next_s = 1'b0;
        end else if (consume_s) begin
            if (skid_valid_r) begin
                out_load_s        = 1'b1;
                out_from_skid_s   = 1'b1;
                out_valid_next_s  = 1'b1;
                skid_valid_next_s = 1'b0;
            end else if (accept_s) begin
                out_load_s       = 1'b1;
                out_valid_next_s = 1'b1;
            end else begin
                out_valid_next_s = 1'b0;
            end
        end else if (accept_s) begin
            if (out_valid_r) begin
                skid_load_s       = 1'b1;
                skid_valid_next_s = 1'b1;
            end else begin
                out_load_s       = 1'b1;
                out_valid_next_s = 1'b1;
            end
        end else begin
            out_valid_next_s = out_valid_r;
        end
    end

    // Output payload comes from the skid when draining it, otherwise from decode.
    always_comb begin
        if (out_from_skid_s) begin
            out_next_s = skid_r;
        end else begin
            out_next_s = dec_s;
        end
    end

    // Skid entry: captures a decoded instruction accepted during an output stall.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            skid_valid_r <= 1'b0;
            skid_r       <= '0;
        end else begin
            skid_valid_r <= skid_valid_next_s;
            if (skid_load_s) begin
                skid_r <= dec_s;
            end
        end
    end
`else
    // Without a skid, accept only when the output register frees up this cycle.
    assign in_ready_s = rst_n && !bus.flush && (!out_valid_r || bus.out_ready);

    // Next-state for the single output register. Flush wins over accept and consume.
    always_comb begin
        out_valid_next_s = out_valid_r;
        out_load_s       = 1'b0;
        out_next_s       = dec_s;
        if (bus.flush) begin
            out_valid_next_s = 1'b0;
        end else if (accept_s) begin
            out_load_s       = 1'b1;
            out_valid_next_s = 1'b1;
        end else if (consume_s) begin
            out_valid_next_s = 1'b0;
        end else begin
            out_valid_next_s = out_valid_r;
        end
    end
`endif

    // Output register: payload changes only on load, so it holds stable during a stall.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_r       <= '0;
        end else begin
            out_valid_r <= out_valid_next_s;
            if (out_load_s) begin
                out_r <= out_next_s;
            end
        end
    end

    assign bus.in_ready    = in_ready_s;
    assign bus.out_valid   = out_valid_r;
    assign bus.out_pc      = out_r.pc;
    assign bus.out_rs1     = out_r.rs1;
    assign bus.out_rs2     = out_r.rs2;
    assign bus.out_rd      = out_r.rd;
    assign bus.out_imm     = out_r.imm;
    assign bus.out_control = out_r.control;
    assign bus.out_illegal = out_r.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage. A transaction-level model keeps a queue of
// decoded instructions the stage must hold. The queue is pushed on accept,
// popped on consume, and cleared on flush or reset. It is checked against
// the DUT on every falling edge. Directed scenarios add literal expectations.
module tb_decode_stage;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [8:0]  ctrl;
        logic        ill;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;
    logic accepted = 1'b0;
    logic live = 1'b0;

    exp_t q[$];
    logic smp_rst = 1'b0;
    logic smp_flush = 1'b0;
    logic smp_acc = 1'b0;
    logic smp_cons = 1'b0;
    exp_t smp_item;

    decode_stage_if bus ();

    decode_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] rom_lookup(input logic [8:0] a);
        if (a == 9'h00C)      return 9'h010;
        else if (a == 9'h104) return 9'h011;
        else if (a == 9'h000) return 9'h000;
        else                  return a ^ 9'h0A5;
    endfunction

    assign bus.rom_control = rom_lookup(bus.rom_addr);

    function automatic exp_t model(input logic [31:0] i, input logic [31:0] pc);
        exp_t        e;
        logic [11:0] i12;
        logic [12:0] b13;
        logic [20:0] j21;
        logic [8:0]  rc;
        e     = '0;
        e.pc  = pc;
        e.rs1 = i[19:15];
        e.rs2 = i[24:20];
        e.rd  = i[11:7];
        case (i[6:2])
            5'b00100, 5'b00000, 5'b11001: begin i12 = i[31:20]; e.imm = 32'($signed(i12)); end
            5'b01000: begin i12 = {i[31:25], i[11:7]}; e.imm = 32'($signed(i12)); end
            5'b11000: begin b13 = {i[31], i[7], i[30:25], i[11:8], 1'b0}; e.imm = 32'($signed(b13)); end
            5'b01101, 5'b00101: e.imm = {i[31:12], 12'h000};
            5'b11011: begin j21 = {i[31], i[19:12], i[20], i[30:21], 1'b0}; e.imm = 32'($signed(j21)); end
            default: e.imm = 32'h0;
        endcase
        rc     = rom_lookup({i[30], i[14:12], i[6:2]});
        e.ill  = (i[1:0] != 2'b11) || (rc == 9'h000);
        e.ctrl = e.ill ? 9'h000 : rc;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, then sample this cycle's handshakes.
    always @(negedge clk) begin
        logic exp_ready;
        if (live) begin
`ifdef DECODE_SKID_EN
            exp_ready = rst_n && !bus.flush && (q.size() < 2);
`else
            exp_ready = rst_n && !bus.flush && ((q.size() == 0) || bus.out_ready);
`endif
            chk("in_ready", {31'b0, bus.in_ready}, {31'b0, exp_ready});
            chk("out_valid", {31'b0, bus.out_valid}, {31'b0, q.size() != 0});
            chk("rom_addr", {23'b0, bus.rom_addr},
                {23'b0, bus.in_instr[30], bus.in_instr[14:12], bus.in_instr[6:2]});
            if (q.size() != 0) begin
                chk("out_pc", bus.out_pc, q[0].pc);
                chk("out_rs1", {27'b0, bus.out_rs1}, {27'b0, q[0].rs1});
                chk("out_rs2", {27'b0, bus.out_rs2}, {27'b0, q[0].rs2});
                chk("out_rd", {27'b0, bus.out_rd}, {27'b0, q[0].rd});
                chk("out_imm", bus.out_imm, q[0].imm);
                chk("out_control", {23'b0, bus.out_control}, {23'b0, q[0].ctrl});
                chk("out_illegal", {31'b0, bus.out_illegal}, {31'b0, q[0].ill});
            end
        end
        smp_rst   = rst_n;
        smp_flush = bus.flush;
        smp_acc   = bus.in_valid && bus.in_ready;
        smp_cons  = bus.out_valid && bus.out_ready;
        smp_item  = model(bus.in_instr, bus.in_pc);
    end

    // Model update at each rising edge from the sampled handshakes.
    always @(posedge clk) begin
        if (!smp_rst || smp_flush) begin
            q.delete();
        end else begin
            if (smp_cons && q.size() != 0) void'(q.pop_front());
            if (smp_acc) q.push_back(smp_item);
        end
        live = 1'b1;
    end

    // One clock: note whether the presented instruction was taken, drop valid if so.
    task automatic cycle();
        logic a;
        @(negedge clk);
        a = bus.in_valid && bus.in_ready;
        @(posedge clk);
        #1;
        accepted = a;
        if (a) bus.in_valid = 1'b0;
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc);
        bus.in_instr = instr;
        bus.in_pc    = pc;
        bus.in_valid = 1'b1;
    endtask

    logic [31:0] stream [10] = '{32'hFE112E23, 32'hFE000EE3, 32'h12345037, 32'h0080006F,
                                 32'h00000097, 32'h000080E7, 32'h00000010, 32'h40208033,
                                 32'h0000000B, 32'h002081B3};

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_instr  = 32'h0;
        bus.in_pc     = 32'h0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;

        // Reset state
        repeat (3) cycle();
        chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd0);
        chk("rst_out_pc", bus.out_pc, 32'd0);
        chk("rst_out_imm", bus.out_imm, 32'd0);
        chk("rst_out_control", {23'b0, bus.out_control}, 32'd0);
        chk("rst_regs", {17'b0, bus.out_rs1, bus.out_rs2, bus.out_rd}, 32'd0);
        chk("rst_out_illegal", {31'b0, bus.out_illegal}, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("in_ready_after_release", {31'b0, bus.in_ready}, 32'd1);

        // ADD x3,x1,x2
        bus.out_ready = 1'b1;
        drive(32'h002081B3, 32'h0000_1000);
        #1;
        chk("add_rom_addr", {23'b0, bus.rom_addr}, 32'h00C);
        cycle();
        chk("add_accepted", {31'b0, accepted}, 32'd1);
        chk("add_out_valid", {31'b0, bus.out_valid}, 32'd1);
        chk("add_regs", {17'b0, bus.out_rs1, bus.out_rs2, bus.out_rd}, {17'b0, 5'd1, 5'd2, 5'd3});
        chk("add_control", {23'b0, bus.out_control}, 32'h010);
        chk("add_illegal", {31'b0, bus.out_illegal}, 32'd0);
        chk("add_pc", bus.out_pc, 32'h0000_1000);

        // ADDI x5,x0,-1
        drive(32'hFFF00293, 32'h0000_1004);
        #1;
        chk("addi_rom_addr", {23'b0, bus.rom_addr}, 32'h104);
        cycle();
        chk("addi_imm", bus.out_imm, 32'hFFFF_FFFF);
        chk("addi_rd", {27'b0, bus.out_rd}, 32'd5);
        chk("addi_control", {23'b0, bus.out_control}, 32'h011);

        // SW x1,-4(x2): S-type immediate
        drive(32'hFE112E23, 32'h0000_1008);
        cycle();
        chk("sw_imm", bus.out_imm, 32'hFFFF_FFFC);

        // LUI: U-type immediate keeps low 12 bits zero
        drive(32'h12345037, 32'h0000_100C);
        cycle();
        chk("lui_imm", bus.out_imm, 32'h1234_5000);

        // All-zero word: illegal with zero control
        drive(32'h0000_0000, 32'h0000_1010);
        cycle();
        chk("zero_illegal", {31'b0, bus.out_illegal}, 32'd1);
        chk("zero_control", {23'b0, bus.out_control}, 32'd0);

        // Low bits not 11 while ROM is nonzero: still illegal
        drive(32'h0000_0010, 32'h0000_1014);
        cycle();
        chk("lowbits_illegal", {31'b0, bus.out_illegal}, 32'd1);
        chk("lowbits_control", {23'b0, bus.out_control}, 32'd0);

        // One instruction per cycle with out_ready held high
        foreach (stream[k]) begin
            drive(stream[k], 32'h0000_2000 + 32'(k) * 32'd4);
            cycle();
            chk("throughput", {31'b0, accepted}, 32'd1);
        end
        cycle();

        // Back-to-back pair at 0x100/0x104 into a three-cycle stall
        bus.out_ready = 1'b0;
        drive(32'h002081B3, 32'h0000_0100);
        cycle();
        chk("pair_first_accepted", {31'b0, accepted}, 32'd1);
        drive(32'hFFF00293, 32'h0000_0104);
        cycle();
`ifdef DECODE_SKID_EN
        chk("pair_second_to_skid", {31'b0, accepted}, 32'd1);
`else
        chk("pair_second_held", {31'b0, accepted}, 32'd0);
`endif
        chk("pair_in_ready_low", {31'b0, bus.in_ready}, 32'd0);
        chk("pair_out_pc_first", bus.out_pc, 32'h0000_0100);
        cycle();
        cycle();
        chk("pair_hold_pc", bus.out_pc, 32'h0000_0100);
        bus.out_ready = 1'b1;
        cycle();
        chk("pair_out_pc_second", bus.out_pc, 32'h0000_0104);
        chk("pair_second_valid", {31'b0, bus.out_valid}, 32'd1);
        cycle();
        chk("pair_drained", {31'b0, bus.out_valid}, 32'd0);

        // Flush with output valid and a second instruction pending
        bus.out_ready = 1'b0;
        drive(32'h002081B3, 32'h0000_0200);
        cycle();
        drive(32'hFFF00293, 32'h0000_0204);
        cycle();
        drive(32'h40208033, 32'h0000_0208);
        bus.flush = 1'b1;
        #1;
        chk("flush_in_ready", {31'b0, bus.in_ready}, 32'd0);
        cycle();
        bus.flush = 1'b0;
        chk("flush_not_accepted", {31'b0, accepted}, 32'd0);
        chk("flush_out_valid", {31'b0, bus.out_valid}, 32'd0);
        bus.out_ready = 1'b1;
        cycle();
        chk("post_flush_accepted", {31'b0, accepted}, 32'd1);
        chk("post_flush_pc", bus.out_pc, 32'h0000_0208);
        chk("post_flush_control", {23'b0, bus.out_control}, 32'h1A9);
        cycle();

        // Reset in the middle of a stall
        bus.out_ready = 1'b0;
        drive(32'h002081B3, 32'h0000_0300);
        cycle();
        drive(32'hFFF00293, 32'h0000_0304);
        cycle();
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        cycle();
        chk("midstall_rst_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("midstall_rst_ready", {31'b0, bus.in_ready}, 32'd0);
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        for (int n = 0; n < 4; n++) begin
            cycle();
            chk("no_stale_after_rst", {31'b0, bus.out_valid}, 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
